bus_frame_responder: RTL and testbench



---
 rtl/bus_pkg.sv | 37 +++
 rtl/resp_fifo.sv | 66 ++++++
 rtl/bus_frame_responder.sv | 175 +++++++++++++++++
 tb/tb_bus_frame_responder.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/bus_pkg.sv
// Shared definitions for the 8-bit crypto interconnect bus.
// Contents: endpoint ids, header field positions, the length decode,
// the responder FSM state type and the buffered payload entry.
package bus_pkg;

   localparam logic [1:0] ID_B    = 2'b00;
   localparam logic [1:0] ID_SHA  = 2'b01;
   localparam logic [1:0] ID_AES  = 2'b10;
   localparam logic [1:0] ID_CTRL = 2'b11;

   // Header byte: [7:6] dest, [5:4] src, [3:0] len
   localparam int HDR_DEST_MSB = 7;
   localparam int HDR_DEST_LSB = 6;
   localparam int HDR_SRC_MSB  = 5;
   localparam int HDR_SRC_LSB  = 4;
   localparam int HDR_LEN_MSB  = 3;
   localparam int HDR_LEN_LSB  = 0;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RECV = 2'd1,
      ST_SKIP = 2'd2,
      ST_ACK  = 2'd3
   } state_t;

   typedef struct packed {
      logic [1:0] src;
      logic       last;
      logic [7:0] data;
   } entry_t;

   // A length field of 0 means a full 16-byte payload.
   function automatic logic [4:0] decode_len(input logic [3:0] len);
      return (len == 4'd0) ? 5'd16 : {1'b0, len};
   endfunction

endpackage

// File: rtl/resp_fifo.sv
// Commit/rollback FIFO for the bus frame responder.
// Writes advance a speculative pointer; only committed entries are visible
// to the reader. Rollback discards everything written since the last commit.
// Ports:
//   clk, rst       clock, synchronous active-high reset
//   wr_en/wr_entry speculative write
//   commit         publish all speculative entries
//   rollback       drop all uncommitted entries
//   rd_en          pop the head entry (ignored when empty)
//   rd_entry       head entry, zero when empty
//   valid          a committed entry is available
//   free           DEPTH minus entries held (committed + speculative)
module resp_fifo
   import bus_pkg::*;
#(
   parameter int DEPTH = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     wr_en,
   input  entry_t                   wr_entry,
   input  logic                     commit,
   input  logic                     rollback,
   input  logic                     rd_en,
   output entry_t                   rd_entry,
   output logic                     valid,
   output logic [$clog2(DEPTH):0]   free
);

   localparam int AW = $clog2(DEPTH);

   logic [AW:0] wr_ptr;
   logic [AW:0] cm_ptr;
   logic [AW:0] rd_ptr;
   entry_t      mem [DEPTH];

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         cm_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (rollback)
            wr_ptr <= cm_ptr;
         else if (wr_en)
            wr_ptr <= wr_ptr + (AW+1)'(1);
         if (commit)
            cm_ptr <= wr_ptr;
         if (rd_en && valid)
            rd_ptr <= rd_ptr + (AW+1)'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en)
         mem[wr_ptr[AW-1:0]] <= wr_entry;
   end

   assign valid    = (rd_ptr != cm_ptr);
   // Gate the head so the outputs read as zero when nothing is committed.
   assign rd_entry = valid ? mem[rd_ptr[AW-1:0]] : '0;
   // Measured against the speculative pointer so that a header arriving in
   // the commit cycle already sees the space taken by the frame being acked.
   assign free     = (AW+1)'(DEPTH) - (wr_ptr - rd_ptr);

endmodule

// File: rtl/bus_frame_responder.sv
// Receiving endpoint of the shared 8-bit crypto bus.
// Accepts frames addressed to MY_ID, buffers the payload, pulses ack after
// the last byte and then streams the payload to the local core.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   bus_valid, bus_data      shared bus byte strobe and byte
//   ack                      1-cycle pulse, frame accepted
//   out_valid/out_ready      payload handshake to the local core
//   out_data/out_src/out_last payload byte, source id, end-of-frame flag
//   drop                     1-cycle pulse, frame discarded (overflow/timeout)
//   busy                     FSM not in IDLE
//
// state | meaning
// IDLE  | waiting for a header byte
// RECV  | storing payload of a frame addressed here
// SKIP  | consuming payload of a frame not stored
// ACK   | ack pulse and commit; a header here is handled as in IDLE
module bus_frame_responder
   import bus_pkg::*;
#(
   parameter logic [1:0] MY_ID   = ID_AES,
   parameter int         DEPTH   = 16,
   parameter int         TIMEOUT = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       bus_valid,
   input  logic [7:0] bus_data,
   output logic       ack,
   output logic       out_valid,
   input  logic       out_ready,
   output logic [7:0] out_data,
   output logic [1:0] out_src,
   output logic       out_last,
   output logic       drop,
   output logic       busy
);

   localparam int AW = $clog2(DEPTH);
   localparam int IW = $clog2(TIMEOUT + 1);

   if (DEPTH < 16 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
      $error("bus_frame_responder: DEPTH must be a power of two >= 16");
   end
   if (TIMEOUT < 1) begin : g_bad_timeout
      $error("bus_frame_responder: TIMEOUT must be >= 1");
   end

   state_t        state, state_next;
   logic [4:0]    remaining, remaining_next;
   logic [IW-1:0] idle_cnt, idle_cnt_next;
   logic [1:0]    src_q, src_next;
   logic          drop_q, drop_next;

   logic          wr_en;
   logic          commit;
   logic          rollback;
   entry_t        wr_entry;
   entry_t        rd_entry;
   logic [AW:0]   free;

   logic [1:0]    hdr_dest;
   logic [1:0]    hdr_src;
   logic [4:0]    hdr_len;
   logic [AW:0]   hdr_len_w;

   assign hdr_dest  = bus_data[HDR_DEST_MSB:HDR_DEST_LSB];
   assign hdr_src   = bus_data[HDR_SRC_MSB:HDR_SRC_LSB];
   assign hdr_len   = decode_len(bus_data[HDR_LEN_MSB:HDR_LEN_LSB]);
   assign hdr_len_w = (AW+1)'(hdr_len);

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= ST_IDLE;
         remaining <= '0;
         idle_cnt  <= '0;
         src_q     <= '0;
         drop_q    <= 1'b0;
      end else begin
         state     <= state_next;
         remaining <= remaining_next;
         idle_cnt  <= idle_cnt_next;
         src_q     <= src_next;
         drop_q    <= drop_next;
      end
   end

   always_comb begin
      state_next     = state;
      remaining_next = remaining;
      idle_cnt_next  = idle_cnt;
      src_next       = src_q;
      drop_next      = 1'b0;
      wr_en          = 1'b0;
      rollback       = 1'b0;
      commit         = (state == ST_ACK);
      wr_entry       = '{src: src_q, last: (remaining == 5'd1), data: bus_data};

      case (state)
         ST_IDLE, ST_ACK: begin
            state_next = ST_IDLE;
            if (bus_valid) begin
               remaining_next = hdr_len;
               idle_cnt_next  = IW'(TIMEOUT);
               if (hdr_dest != MY_ID) begin
                  state_next = ST_SKIP;
               end else if (free >= hdr_len_w) begin
                  state_next = ST_RECV;
                  src_next   = hdr_src;
               end else begin
                  state_next = ST_SKIP;
                  drop_next  = 1'b1;
               end
            end
         end

         ST_RECV: begin
            if (bus_valid) begin
               wr_en          = 1'b1;
               idle_cnt_next  = IW'(TIMEOUT);
               remaining_next = remaining - 5'd1;
               if (remaining == 5'd1)
                  state_next = ST_ACK;
            end else if (idle_cnt == IW'(1)) begin
               rollback   = 1'b1;
               drop_next  = 1'b1;
               state_next = ST_IDLE;
            end else begin
               idle_cnt_next = idle_cnt - IW'(1);
            end
         end

         ST_SKIP: begin
            if (bus_valid) begin
               idle_cnt_next  = IW'(TIMEOUT);
               remaining_next = remaining - 5'd1;
               if (remaining == 5'd1)
                  state_next = ST_IDLE;
            end else if (idle_cnt == IW'(1)) begin
               // Nothing was written, so the rollback is a no-op; no drop
               // is reported for frames that were never ours to keep.
               rollback   = 1'b1;
               state_next = ST_IDLE;
            end else begin
               idle_cnt_next = idle_cnt - IW'(1);
            end
         end

         default: state_next = ST_IDLE;
      endcase
   end

   resp_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk      (clk),
      .rst      (rst),
      .wr_en    (wr_en),
      .wr_entry (wr_entry),
      .commit   (commit),
      .rollback (rollback),
      .rd_en    (out_ready),
      .rd_entry (rd_entry),
      .valid    (out_valid),
      .free     (free)
   );

   assign ack      = (state == ST_ACK);
   assign busy     = (state != ST_IDLE);
   assign drop     = drop_q;
   assign out_data = rd_entry.data;
   assign out_src  = rd_entry.src;
   assign out_last = rd_entry.last;

endmodule

// File: tb/tb_bus_frame_responder.sv
module tb_bus_frame_responder;
   import bus_pkg::*;

   logic       clk = 1'b0;
   logic       rst;
   logic       bus_valid;
   logic [7:0] bus_data;
   logic       ack;
   logic       out_valid;
   logic       out_ready;
   logic [7:0] out_data;
   logic [1:0] out_src;
   logic       out_last;
   logic       drop;
   logic       busy;

   always #5 clk = ~clk;

   bus_frame_responder dut (
      .clk       (clk),
      .rst       (rst),
      .bus_valid (bus_valid),
      .bus_data  (bus_data),
      .ack       (ack),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_src   (out_src),
      .out_last  (out_last),
      .drop      (drop),
      .busy      (busy)
   );

   int     n_checks = 0;
   int     n_fail   = 0;
   int     ack_cnt  = 0;
   int     drop_cnt = 0;
   bit     rnd_ready = 1'b0;
   entry_t exp_q[$];
   entry_t mon_exp;
   entry_t mon_got;

   typedef struct {
      logic [7:0] hdr;
      int         n;
      logic [7:0] base;
      logic [7:0] stride;
      bit         exp_ack;
      bit         exp_drop;
   } vec_t;

   vec_t vecs[6];

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, required %0h", name, act, exp);
      end
   endtask

   // Payload monitor: a transfer happens at the next edge when both
   // out_valid and out_ready are high at the falling edge.
   always @(negedge clk) begin
      if (ack)  ack_cnt++;
      if (drop) drop_cnt++;
      if (!rst && out_valid && out_ready) begin
         n_checks++;
         mon_got = '{src: out_src, last: out_last, data: out_data};
         if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL out_unexpected: got src %0d last %0d data %0h, required no byte",
                     out_src, out_last, out_data);
         end else begin
            mon_exp = exp_q.pop_front();
            if (mon_got !== mon_exp) begin
               n_fail++;
               $display("FAIL out_byte: got src %0d last %0d data %0h, required src %0d last %0d data %0h",
                        mon_got.src, mon_got.last, mon_got.data,
                        mon_exp.src, mon_exp.last, mon_exp.data);
            end
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic send_byte(input logic [7:0] b);
      bus_valid = 1'b1;
      bus_data  = b;
      if (rnd_ready) out_ready = 1'($urandom_range(0, 1));
      step();
      bus_valid = 1'b0;
      bus_data  = 8'h00;
   endtask

   task automatic push_exp(input logic [1:0] src, input logic last, input logic [7:0] data);
      exp_q.push_back('{src: src, last: last, data: data});
   endtask

   task automatic wait_drain(input string name);
      for (int i = 0; i < 100 && exp_q.size() != 0; i++) step();
      step();
      chk({name, "_drain_left"}, exp_q.size(), 0);
      chk({name, "_valid_after_drain"}, int'(out_valid), 0);
   endtask

   task automatic run_vec(input int idx, input vec_t v);
      int         a0, d0;
      logic [7:0] b;
      string      nm;
      nm = $sformatf("vec%0d", idx);
      a0 = ack_cnt;
      d0 = drop_cnt;
      send_byte(v.hdr);
      chk({nm, "_drop_after_hdr"}, int'(drop), int'(v.exp_drop));
      for (int i = 0; i < v.n; i++) begin
         b = v.base + 8'(v.stride * 8'(i));
         if (v.exp_ack) push_exp(v.hdr[5:4], (i == v.n - 1), b);
         send_byte(b);
      end
      chk({nm, "_ack_after_last"}, int'(ack), int'(v.exp_ack));
      step();
      chk({nm, "_ack_one_cycle"}, int'(ack), 0);
      wait_drain(nm);
      chk({nm, "_ack_count"}, ack_cnt - a0, int'(v.exp_ack));
      chk({nm, "_drop_count"}, drop_cnt - d0, int'(v.exp_drop));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int a0, d0;

      vecs[0] = '{8'b10_01_0011, 3,  8'hA1, 8'h01, 1'b1, 1'b0};
      vecs[1] = '{8'b11_01_0010, 2,  8'h55, 8'h11, 1'b0, 1'b0};
      vecs[2] = '{8'b10_11_0001, 1,  8'h77, 8'h00, 1'b1, 1'b0};
      vecs[3] = '{8'b00_10_0001, 1,  8'h42, 8'h00, 1'b0, 1'b0};
      vecs[4] = '{8'b10_10_1111, 15, 8'h10, 8'h01, 1'b1, 1'b0};
      vecs[5] = '{8'b10_00_0000, 16, 8'h80, 8'h03, 1'b1, 1'b0};

      rst       = 1'b1;
      bus_valid = 1'b0;
      bus_data  = 8'h00;
      out_ready = 1'b0;
      step(); step(); step();
      rst = 1'b0;
      step();
      chk("reset_outputs", int'({ack, drop, busy, out_valid, out_data, out_src, out_last}), 0);

      out_ready = 1'b1;
      for (int i = 0; i < 6; i++) run_vec(i, vecs[i]);

      // Full FIFO, then an overflowing frame
      out_ready = 1'b0;
      a0 = ack_cnt;
      d0 = drop_cnt;
      send_byte(8'b10_01_0000);
      for (int i = 0; i < 16; i++) begin
         push_exp(2'b01, (i == 15), 8'hC0 + 8'(i));
         send_byte(8'hC0 + 8'(i));
      end
      chk("full_ack", int'(ack), 1);
      step();
      chk("full_valid", int'(out_valid), 1);
      send_byte(8'b10_01_0001);
      chk("ovf_drop", int'(drop), 1);
      chk("ovf_busy", int'(busy), 1);
      send_byte(8'hEE);
      chk("ovf_no_ack", int'(ack), 0);
      step();
      chk("ovf_ack_count", ack_cnt - a0, 1);
      chk("ovf_drop_count", drop_cnt - d0, 1);
      out_ready = 1'b1;
      wait_drain("full");

      // Mid-frame timeout
      a0 = ack_cnt;
      send_byte(8'b10_00_0100);
      send_byte(8'h11);
      send_byte(8'h22);
      for (int i = 0; i < 7; i++) step();
      chk("tmo_busy_before", int'(busy), 1);
      chk("tmo_drop_before", int'(drop), 0);
      step();
      chk("tmo_drop", int'(drop), 1);
      chk("tmo_busy_after", int'(busy), 0);
      step();
      chk("tmo_drop_pulse", int'(drop), 0);
      chk("tmo_no_valid", int'(out_valid), 0);
      chk("tmo_no_ack", ack_cnt - a0, 0);
      send_byte(8'b10_00_0001);
      push_exp(2'b00, 1'b1, 8'h3C);
      send_byte(8'h3C);
      chk("tmo_next_ack", int'(ack), 1);
      wait_drain("tmo");

      // Reset mid-frame discards committed and speculative data
      out_ready = 1'b0;
      send_byte(8'b10_01_0001);
      send_byte(8'h99);
      step();
      chk("rst_pre_valid", int'(out_valid), 1);
      send_byte(8'b10_01_0100);
      send_byte(8'h01);
      send_byte(8'h02);
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("rst_mid_outputs", int'({ack, drop, busy, out_valid, out_data, out_src, out_last}), 0);
      out_ready = 1'b1;
      send_byte(8'b10_10_0010);
      push_exp(2'b10, 1'b0, 8'h5A);
      send_byte(8'h5A);
      push_exp(2'b10, 1'b1, 8'hA5);
      send_byte(8'hA5);
      chk("rst_next_ack", int'(ack), 1);
      wait_drain("rst");

      // Header arriving in the ACK cycle, random backpressure
      rnd_ready = 1'b1;
      a0 = ack_cnt;
      push_exp(2'b01, 1'b0, 8'hD1);
      push_exp(2'b01, 1'b1, 8'hD2);
      send_byte(8'b10_01_0010);
      send_byte(8'hD1);
      send_byte(8'hD2);
      chk("b2b_ack1", int'(ack), 1);
      push_exp(2'b11, 1'b0, 8'hE1);
      push_exp(2'b11, 1'b0, 8'hE2);
      push_exp(2'b11, 1'b1, 8'hE3);
      send_byte(8'b10_11_0011);
      chk("b2b_hdr_in_ack", int'(busy && !ack), 1);
      send_byte(8'hE1);
      send_byte(8'hE2);
      send_byte(8'hE3);
      chk("b2b_ack2", int'(ack), 1);
      rnd_ready = 1'b0;
      out_ready = 1'b1;
      step();
      wait_drain("b2b");
      chk("b2b_ack_count", ack_cnt - a0, 2);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
